// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: state encoding,
// register-file geometry and the default word width.
package reg_dump_reader_pkg;

    localparam int         REG_COUNT    = 32;
    localparam logic [4:0] LAST_REG     = 5'd31;
    localparam int         DEFAULT_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2
    } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks the register file through a combinational read port and streams
// each register out over a valid/ready handshake, one word every two cycles.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter bit SKIP_X0 = 1'b0,
    parameter int XLEN    = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    output logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            halt_req,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_index,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic [4:0]        out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // start wins over a simultaneous abort; abort alone is a no-op here
                if (start) begin
                    idx_d   = SKIP_X0 ? 5'd1 : 5'd0;
                    state_d = READ;
                end
            end
            READ: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_data_d  = rd_data;
                    out_index_d = idx_q;
                    out_valid_d = 1'b1;
                    out_last_d  = (idx_q == LAST_REG);
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_REG) begin
                        out_last_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        // idx never leaves SEND at LAST_REG through this path, so no wrap
                        idx_d   = idx_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = (state_q == READ) ? idx_q : 5'd0;
    assign busy      = (state_q != IDLE);
    assign halt_req  = busy;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: unit 0 dumps from x0, unit 1 skips x0;
// both read a register file model holding xN = 0x1000_0000 + N.
module tb_reg_dump_reader;

    logic        clk;
    logic        reset;
    logic        start_v     [2];
    logic        abort_v     [2];
    logic        ready_v     [2];
    logic [4:0]  rd_addr_v   [2];
    logic [31:0] rd_data_v   [2];
    logic        halt_v      [2];
    logic        out_valid_v [2];
    logic [31:0] out_data_v  [2];
    logic [4:0]  out_index_v [2];
    logic        out_last_v  [2];
    logic        busy_v      [2];
    logic        done_v      [2];

    int errors = 0;
    int checks = 0;

    assign rd_data_v[0] = 32'h1000_0000 + {27'd0, rd_addr_v[0]};
    assign rd_data_v[1] = 32'h1000_0000 + {27'd0, rd_addr_v[1]};

    reg_dump_reader #(.SKIP_X0(1'b0), .XLEN(32)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
        .rd_addr(rd_addr_v[0]), .rd_data(rd_data_v[0]), .halt_req(halt_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(ready_v[0]), .out_data(out_data_v[0]),
        .out_index(out_index_v[0]), .out_last(out_last_v[0]), .busy(busy_v[0]),
        .done(done_v[0])
    );

    reg_dump_reader #(.SKIP_X0(1'b1), .XLEN(32)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
        .rd_addr(rd_addr_v[1]), .rd_data(rd_data_v[1]), .halt_req(halt_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(ready_v[1]), .out_data(out_data_v[1]),
        .out_index(out_index_v[1]), .out_last(out_last_v[1]), .busy(busy_v[1]),
        .done(done_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until unit u presents word idx; leaves us at that negedge.
    task automatic wait_word(input int u, input int idx, input string tag);
        int n = 0;
        while (!(out_valid_v[u] === 1'b1 && out_index_v[u] === 5'(idx)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < 200), 64'd1);
    endtask

    // Runs one complete dump on unit u with ready high except for an optional
    // 5-cycle stall at index stall_at, and an optional start pulse at restart_at.
    task automatic dump(input int u, input int stall_at, input int restart_at,
                        input int exp_first, input int exp_words, input int exp_cycles,
                        input string tag);
        int c = 0, words = 0, bad = 0, busy_bad = 0, addr_bad = 0;
        int done_c = -1, stall_left = 0, stall_xfers = 0, expi;
        bit stalled = 0, restarted = 0, pending = 0;
        expi = exp_first;
        ready_v[u] = 1'b1;
        @(negedge clk); start_v[u] = 1'b1;
        @(negedge clk); start_v[u] = 1'b0;
        while (done_c < 0 && c < 400) begin
            start_v[u] = 1'b0;
            if (halt_v[u] !== busy_v[u]) busy_bad++;
            if (done_v[u] === 1'b1) done_c = c;
            else if (busy_v[u] !== 1'b1) busy_bad++;
            if (busy_v[u] === 1'b1 && out_valid_v[u] === 1'b0 && rd_addr_v[u] !== 5'(expi)) addr_bad++;
            if ((busy_v[u] !== 1'b1 || out_valid_v[u] === 1'b1) && rd_addr_v[u] !== 5'd0) addr_bad++;
            if (pending && out_valid_v[u] !== 1'b1) bad++;
            if (out_valid_v[u] === 1'b1) begin
                if (out_index_v[u] !== 5'(expi) || out_data_v[u] !== 32'h1000_0000 + 32'(expi)
                    || out_last_v[u] !== (expi == 31)) bad++;
                if (expi == stall_at && !stalled) begin
                    stalled = 1; stall_left = 5; ready_v[u] = 1'b0;
                end else if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) ready_v[u] = 1'b1;
                end
                if (expi == restart_at && !restarted) begin
                    restarted = 1; start_v[u] = 1'b1;
                end
                if (ready_v[u] === 1'b1) begin
                    words++;
                    if (expi == stall_at) stall_xfers++;
                    expi++;
                    pending = 0;
                end else pending = 1;
            end
            @(negedge clk);
            c++;
        end
        start_v[u] = 1'b0;
        chk({tag, " words"}, 64'(words), 64'(exp_words));
        chk({tag, " payload"}, 64'(bad), 64'd0);
        chk({tag, " busy/halt"}, 64'(busy_bad), 64'd0);
        chk({tag, " rd_addr"}, 64'(addr_bad), 64'd0);
        chk({tag, " cycles"}, 64'(done_c), 64'(exp_cycles));
        if (stall_at >= 0) chk({tag, " stall xfers"}, 64'(stall_xfers), 64'd1);
        chk({tag, " idle valid"}, {62'd0, out_valid_v[u], out_last_v[u]}, 64'd0);
        chk({tag, " done pulse"}, 64'(done_v[u]), 64'd0);
        $display("dump %s: words=%0d cycles=%0d", tag, words, done_c);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; abort_v[i] = 1'b0; ready_v[i] = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        chk("reset outputs", {out_valid_v[0], out_last_v[0], busy_v[0], halt_v[0], done_v[0],
            rd_addr_v[0], out_index_v[0], out_data_v[0]}, 64'd0);
        chk("reset outputs skip", {busy_v[1], halt_v[1], out_valid_v[1], rd_addr_v[1]}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("no dump without start", 64'(busy_v[0]), 64'd0);

        dump(0, -1, -1, 0, 32, 64, "full");
        dump(0, 7, -1, 0, 32, 69, "backpressure");
        dump(0, -1, 3, 0, 32, 64, "start while busy");
        dump(1, -1, -1, 1, 31, 62, "skip x0");

        // abort at word 12 with ready high: no transfer, no done
        ready_v[0] = 1'b1;
        start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
        wait_word(0, 12, "reach word 12");
        abort_v[0] = 1'b1;
        @(negedge clk); abort_v[0] = 1'b0;
        chk("abort valid", {62'd0, out_valid_v[0], out_last_v[0]}, 64'd0);
        chk("abort busy", {62'd0, busy_v[0], halt_v[0]}, 64'd0);
        chk("abort no done", 64'(done_v[0]), 64'd0);
        @(negedge clk);
        chk("abort stays idle", {62'd0, busy_v[0], done_v[0]}, 64'd0);
        $display("abort at word 12 done");
        dump(0, -1, -1, 0, 32, 64, "after abort");

        // abort alone in idle, then start with abort together
        abort_v[0] = 1'b1; @(negedge clk); abort_v[0] = 1'b0;
        chk("abort in idle", 64'(busy_v[0]), 64'd0);
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0; abort_v[0] = 1'b0;
        chk("start+abort starts", {59'd0, busy_v[0], rd_addr_v[0]}, {59'd1, 5'd0});
        @(negedge clk);
        chk("start+abort word 0", {31'd0, out_valid_v[0], out_data_v[0]}, {31'd1, 32'h1000_0000});
        abort_v[0] = 1'b1; @(negedge clk); abort_v[0] = 1'b0;
        chk("abort in send", {62'd0, busy_v[0], out_valid_v[0]}, 64'd0);

        // asynchronous reset mid-dump at word 20
        start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
        wait_word(0, 20, "reach word 20");
        #2 reset = 1'b1;
        #1;
        chk("async reset mid-dump", {out_valid_v[0], out_last_v[0], busy_v[0], halt_v[0], done_v[0],
            rd_addr_v[0], out_index_v[0], out_data_v[0]}, 64'd0);
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle after reset", {62'd0, busy_v[0], out_valid_v[0]}, 64'd0);
        $display("reset at word 20 done");
        dump(0, -1, -1, 0, 32, 64, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
